// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes,
// ALU/immediate codes and datapath mux selects.
package riscv_ctrl_pkg;

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECR    = 4'd6;
  localparam logic [3:0] EXECI    = 4'd7;
  localparam logic [3:0] ALUWB    = 4'd8;
  localparam logic [3:0] BEQ      = 4'd9;
  localparam logic [3:0] JAL      = 4'd10;
  localparam logic [3:0] HALT     = 4'd11;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALU    = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALUOUT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decoder: ALUOp plus instruction fields to ALUControl.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] func3,
  input  logic       op5,
  input  logic       func7_5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (func3)
          3'b000:  alu_control = (op5 & func7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the multicycle RV32I datapath. Define RISCV_ILLEGAL_TRAP_EN
// to halt on an illegal opcode; otherwise illegal opcodes retire as NOPs.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = FETCH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       Zero,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       save,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       illegal_op,
  output logic       retire
);

  logic [3:0] state, state_next;
  logic       ir_write, mem_write, adr_src, pc_write, reg_write, save_en, retire_d;
  logic [1:0] result_src, src_a, src_b, alu_op;
  logic [2:0] alu_control;
  logic       unused_func7;

  assign unused_func7 = ^{func7[6], func7[4:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RESET_STATE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = FETCH;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    save_en    = 1'b0;
    retire_d   = 1'b0;
    result_src = RES_ALU;
    src_a      = SRCA_PC;
    src_b      = SRCB_RD2;
    alu_op     = ALUOP_ADD;
    case (state)
      FETCH: begin
        ir_write   = 1'b1;
        src_b      = SRCB_FOUR;
        pc_write   = 1'b1;
        state_next = DECODE;
      end
      DECODE: begin
        src_a   = SRCA_OLDPC;
        src_b   = SRCB_IMM;
        save_en = 1'b1;
        case (opcode)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECR;
          OP_I:         state_next = EXECI;
          OP_BEQ:       state_next = BEQ;
          OP_JAL:       state_next = JAL;
          default: begin
`ifdef RISCV_ILLEGAL_TRAP_EN
            state_next = HALT;
`else
            state_next = FETCH;
            retire_d   = 1'b1;
`endif
          end
        endcase
      end
      MEMADR: begin
        src_a      = SRCA_RD1;
        src_b      = SRCB_IMM;
        save_en    = 1'b1;
        state_next = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        result_src = RES_ALUOUT;
        adr_src    = 1'b1;
        state_next = MEMWB;
      end
      MEMWB: begin
        result_src = RES_MEM;
        reg_write  = 1'b1;
        retire_d   = 1'b1;
      end
      MEMWRITE: begin
        result_src = RES_ALUOUT;
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        retire_d   = 1'b1;
      end
      EXECR, EXECI: begin
        src_a      = SRCA_RD1;
        src_b      = (state == EXECR) ? SRCB_RD2 : SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        save_en    = 1'b1;
        state_next = ALUWB;
      end
      ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        retire_d   = 1'b1;
      end
      BEQ: begin
        src_a      = SRCA_RD1;
        src_b      = SRCB_RD2;
        alu_op     = ALUOP_SUB;
        result_src = RES_ALUOUT;
        pc_write   = Zero;
        retire_d   = 1'b1;
      end
      JAL: begin
        // Jump target was latched in DECODE; ALU now forms OldPC+4 for the link write.
        src_a      = SRCA_OLDPC;
        src_b      = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
        save_en    = 1'b1;
        state_next = ALUWB;
      end
`ifdef RISCV_ILLEGAL_TRAP_EN
      HALT: state_next = HALT;
`endif
      default: state_next = FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .func3       (func3),
    .op5         (opcode[5]),
    .func7_5     (func7[5]),
    .alu_control (alu_control)
  );

  // Every output is held low while reset is asserted, including FETCH's enables.
  assign IRWrite    = reset & ir_write;
  assign MemWrite   = reset & mem_write;
  assign AdrSrc     = reset & adr_src;
  assign PCWrite    = reset & pc_write;
  assign RegWrite   = reset & reg_write;
  assign save       = reset & save_en;
  assign retire     = reset & retire_d;
  assign ResultSrc  = reset ? result_src : 2'b00;
  assign ALUSrcA    = reset ? src_a : 2'b00;
  assign ALUSrcB    = reset ? src_b : 2'b00;
  assign ImmSrc     = reset ? imm_src_of(opcode) : 2'b00;
  assign ALUControl = reset ? alu_control : 3'b000;

`ifdef RISCV_ILLEGAL_TRAP_EN
  assign illegal_op = reset & (state == HALT);
`else
  assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: directed instructions plus a random
// instruction stream checked every cycle against a per-instruction-class model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       Zero;
  logic       IRWrite, MemWrite, AdrSrc, PCWrite, RegWrite, save, illegal_op, retire;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .func3      (func3),
    .func7      (func7),
    .Zero       (Zero),
    .IRWrite    (IRWrite),
    .MemWrite   (MemWrite),
    .AdrSrc     (AdrSrc),
    .PCWrite    (PCWrite),
    .RegWrite   (RegWrite),
    .save       (save),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .illegal_op (illegal_op),
    .retire     (retire)
  );

`ifdef RISCV_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct packed {
    logic       irw, mw, adr, pcw, rw, save;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] alu;
    logic       ill, ret;
  } outs_t;

  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_BEQ = 4, C_JAL = 5, C_ILL = 6;

  wire [18:0] dut_v = {IRWrite, MemWrite, AdrSrc, PCWrite, RegWrite, save, ResultSrc,
                       ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_op, retire};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [18:0] obs, input logic [18:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %05h expected %05h", tag, obs, exp);
    end
  endtask

  function automatic int class_of(input logic [6:0] op);
    case (op)
      7'b0000011: return C_LW;
      7'b0100011: return C_SW;
      7'b0110011: return C_R;
      7'b0010011: return C_I;
      7'b1100011: return C_BEQ;
      7'b1101111: return C_JAL;
      default:    return C_ILL;
    endcase
  endfunction

  function automatic logic [6:0] opcode_of(input int cls);
    case (cls)
      C_LW:    return 7'b0000011;
      C_SW:    return 7'b0100011;
      C_R:     return 7'b0110011;
      C_I:     return 7'b0010011;
      C_BEQ:   return 7'b1100011;
      default: return 7'b1101111;
    endcase
  endfunction

  function automatic int cycles_of(input int cls);
    case (cls)
      C_LW:    return 5;
      C_SW, C_R, C_I, C_JAL: return 4;
      C_BEQ:   return 3;
      default: return TRAP ? 22 : 2;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [6:0] op, input logic [2:0] f3,
                                           input logic [6:0] f7);
    case (f3)
      3'd0:    return (op[5] && f7[5]) ? 3'd1 : 3'd0;
      3'd2:    return 3'd5;
      3'd6:    return 3'd3;
      3'd7:    return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  // Expected outputs in cycle k (0 = FETCH) of an instruction of class cls.
  function automatic outs_t model(input int cls, input int k, input logic z,
                                  input logic [6:0] op, input logic [2:0] f3,
                                  input logic [6:0] f7);
    outs_t o = '0;
    case (cls)
      C_SW:    o.imm = 2'd1;
      C_BEQ:   o.imm = 2'd2;
      C_JAL:   o.imm = 2'd3;
      default: o.imm = 2'd0;
    endcase
    if (k == 0) begin
      o.irw = 1; o.sb = 2'd2; o.pcw = 1;
    end else if (k == 1) begin
      o.sa = 2'd1; o.sb = 2'd1; o.save = 1;
      o.ret = (cls == C_ILL) && !TRAP;
    end else begin
      case (cls)
        C_LW, C_SW: begin
          if (k == 2) begin
            o.sa = 2'd2; o.sb = 2'd1; o.save = 1;
          end else if (cls == C_SW) begin
            o.rs = 2'd2; o.adr = 1; o.mw = 1; o.ret = 1;
          end else if (k == 3) begin
            o.rs = 2'd2; o.adr = 1;
          end else begin
            o.rs = 2'd1; o.rw = 1; o.ret = 1;
          end
        end
        C_R, C_I: begin
          if (k == 2) begin
            o.sa = 2'd2; o.sb = (cls == C_R) ? 2'd0 : 2'd1; o.save = 1;
            o.alu = funct_alu(op, f3, f7);
          end else begin
            o.rs = 2'd2; o.rw = 1; o.ret = 1;
          end
        end
        C_BEQ: begin
          o.sa = 2'd2; o.alu = 3'd1; o.rs = 2'd2; o.pcw = z; o.ret = 1;
        end
        C_JAL: begin
          if (k == 2) begin
            o.sa = 2'd1; o.sb = 2'd2; o.rs = 2'd2; o.pcw = 1; o.save = 1;
          end else begin
            o.rs = 2'd2; o.rw = 1; o.ret = 1;
          end
        end
        default: o.ill = TRAP;
      endcase
    end
    return o;
  endfunction

  // Entered just after a rising edge with the DUT in FETCH; runs up to ncyc cycles
  // (0 = whole instruction) and returns just after a rising edge.
  task automatic run_instr(input logic [31:0] instr, input int ncyc);
    int    cls;
    int    len;
    outs_t exp;
    cls = class_of(instr[6:0]);
    len = (ncyc > 0) ? ncyc : cycles_of(cls);
    opcode = instr[6:0];
    func3  = instr[14:12];
    func7  = instr[31:25];
    for (int k = 0; k < len; k++) begin
      Zero = 1'($urandom);
      #4;
      exp = model(cls, k, Zero, opcode, func3, func7);
      check_eq($sformatf("cls%0d_op%02h_k%0d", cls, opcode, k), dut_v, exp);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset(input int cycles);
    reset = 1'b0;
    #1;
    check_eq("reset_outputs", dut_v, 19'd0);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check_eq("reset_hold", dut_v, 19'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] w;
    int          cls;
    reset  = 1'b0;
    opcode = 7'd0;
    func3  = 3'd0;
    func7  = 7'd0;
    Zero   = 1'b0;
    @(posedge clk);
    #1;
    apply_reset(2);

    run_instr(32'h0080A283, 0);            // lw x5,8(x1)
    run_instr(32'h0050A223, 0);            // sw x5,4(x1)
    run_instr(32'h402081B3, 0);            // sub x3,x1,x2
    run_instr(32'h002081B3, 0);            // add
    run_instr(32'h0020E1B3, 0);            // or
    run_instr(32'h0020F1B3, 0);            // and
    run_instr(32'h0020A1B3, 0);            // slt
    run_instr(32'h40008193, 0);            // addi with func7[5] set stays add
    run_instr(32'h0000006F, 0);            // jal

    // Abort an R-type in EXECR with an asynchronous reset.
    run_instr(32'h402081B3, 2);
    #2;
    apply_reset(2);
    run_instr(32'h00208463, 0);            // beq

    for (int n = 0; n < 60; n++) begin
      w   = $urandom;
      cls = $urandom_range(0, TRAP ? 5 : 6);
      if (cls == C_ILL) begin
        while (class_of(w[6:0]) != C_ILL) w[6:0] = 7'($urandom);
      end else begin
        w[6:0] = opcode_of(cls);
      end
      run_instr(w, 0);
    end

    run_instr(32'h0000007F, 0);            // illegal opcode 0x7F
    if (TRAP) apply_reset(1);
    run_instr(32'h0080A283, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1);
  end

endmodule
